// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - BCD alarm comparator with ring/snooze/timeout FSM (optional ALARM_MISSED_FLAG_EN)
module alarm_unit #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [7:0] h,
    input  logic [7:0] m,
    input  logic [7:0] s,
    input  logic       arm,
    input  logic       set_en,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_minute,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ring,
    output logic       snoozing,
    output logic [3:0] snooze_cnt,
    output logic [7:0] alarm_h,
    output logic [7:0] alarm_m,
    output logic       set_err,
    output logic       missed
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_MIN * 60 - 1);
    localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

    logic [1:0]  state;
    logic        match_d;
    logic        snooze_d;
    logic        stop_d;
    logic [7:0]  ring_timer;
    logic [15:0] snooze_timer;

    logic match;
    logic trigger;
    logic snooze_edge;
    logic stop_edge;
    logic snooze_ok;
    logic ring_timeout;
    logic set_ok;

    // Numeric compare on BCD is decimal-correct once every nibble is a digit.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    assign set_ok      = bcd_ok(set_hour, 8'h23) && bcd_ok(set_minute, 8'h59);
    assign match       = (h == alarm_h) && (m == alarm_m) && (s == 8'h00);
    assign trigger     = arm && match && !match_d && (state == ST_IDLE);
    assign snooze_edge = snooze_btn && !snooze_d;
    assign stop_edge   = stop_btn && !stop_d;
    assign snooze_ok   = snooze_edge && (snooze_cnt < SNOOZE_MAX);

    // Unattended ringing expires only when no higher-priority event claims the cycle.
    assign ring_timeout = (state == ST_RING) && arm && !stop_edge && !snooze_ok &&
                          tick && (ring_timer == RING_LAST);

    assign ring     = (state == ST_RING);
    assign snoozing = (state == ST_SNOOZE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            match_d      <= 1'b0;
            snooze_d     <= 1'b0;
            stop_d       <= 1'b0;
            ring_timer   <= 8'd0;
            snooze_timer <= 16'd0;
            snooze_cnt   <= 4'd0;
            alarm_h      <= 8'h00;
            alarm_m      <= 8'h00;
            set_err      <= 1'b0;
        end else begin
            match_d  <= match;
            snooze_d <= snooze_btn;
            stop_d   <= stop_btn;
            set_err  <= set_en && !set_ok;
            if (set_en && set_ok) begin
                alarm_h <= set_hour;
                alarm_m <= set_minute;
            end

            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state      <= ST_RING;
                        ring_timer <= 8'd0;
                        snooze_cnt <= 4'd0;
                    end else if (stop_edge) begin
                        snooze_cnt <= 4'd0;
                    end
                end
                ST_RING: begin
                    if (!arm) begin
                        state <= ST_IDLE;
                    end else if (stop_edge) begin
                        state      <= ST_IDLE;
                        snooze_cnt <= 4'd0;
                    end else if (snooze_ok) begin
                        state        <= ST_SNOOZE;
                        snooze_cnt   <= snooze_cnt + 4'd1;
                        snooze_timer <= SNOOZE_LOAD;
                    end else if (ring_timeout) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        ring_timer <= ring_timer + 8'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (!arm) begin
                        state <= ST_IDLE;
                    end else if (stop_edge) begin
                        state      <= ST_IDLE;
                        snooze_cnt <= 4'd0;
                    end else if (tick) begin
                        if (snooze_timer == 16'd0) begin
                            state      <= ST_RING;
                            ring_timer <= 8'd0;
                        end else begin
                            snooze_timer <= snooze_timer - 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALARM_MISSED_FLAG_EN
    logic missed_q;

    // Setting on timeout takes precedence over any clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            missed_q <= 1'b0;
        end else if (ring_timeout) begin
            missed_q <= 1'b1;
        end else if (stop_edge || (set_en && set_ok)) begin
            missed_q <= 1'b0;
        end
    end

    assign missed = missed_q;
`else
    assign missed = 1'b0;
`endif

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Downstream consumer of the time-of-day counter's BCD hour/minute/second outputs.
- Holds a programmable BCD alarm time and asserts `ring` when the running time reaches it.
- Manages snooze, stop and auto-timeout through a small FSM.
- Feeds the buzzer/LED driver and the display mode logic.

Parameters:
- SNOOZE_MIN, 5: snooze duration in minutes; countdown = SNOOZE_MIN*60 ticks.
- RING_TIMEOUT_S, 60: seconds of unattended ringing before auto-return to IDLE.
- MAX_SNOOZE, 3: maximum snoozes per alarm event; 1..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse per elapsed second
- h  in  8  current hour, BCD {tens,units}, 00..23
- m  in  8  current minute, BCD, 00..59
- s  in  8  current second, BCD, 00..59
- arm  in  1  level; alarm enabled when 1
- set_en  in  1  one-cycle strobe; load alarm time from set_hour/set_minute
- set_hour  in  8  BCD alarm hour
- set_minute  in  8  BCD alarm minute
- snooze_btn  in  1  synchronous level; rising edge detected internally
- stop_btn  in  1  synchronous level; rising edge detected internally
- ring  out  1  alarm sounding
- snoozing  out  1  FSM in SNOOZE
- snooze_cnt  out  4  snoozes used in the current event
- alarm_h  out  8  stored alarm hour, BCD
- alarm_m  out  8  stored alarm minute, BCD
- set_err  out  1  one-cycle pulse on a rejected set_en
- missed  out  1  sticky missed-alarm flag (optional feature)

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; ring=0, snoozing=0, snooze_cnt=0.
  - alarm_h=8'h00, alarm_m=8'h00, set_err=0, missed=0.
  - Button edge registers and match_d cleared; timers cleared.
  - Reset mid-RING or mid-SNOOZE aborts immediately.
- Set:
  - On set_en, validate: every nibble <=9, hour <=23, minute <=59.
  - Valid: alarm_h/alarm_m update next edge.
  - Invalid: registers unchanged; set_err=1 for exactly one cycle.
  - set_en does not change FSM state; a ringing alarm keeps ringing.
- Match and trigger:
  - match = (h==alarm_h)&&(m==alarm_m)&&(s==8'h00), combinational.
  - match_d = match, registered.
  - Trigger = arm && match && !match_d && state==IDLE.
  - ring goes high on the edge sampling the trigger, i.e. one cycle after the match first appears.
  - A held match does not retrigger.
- FSM states: IDLE, RING, SNOOZE. ring=1 only in RING; snoozing=1 only in SNOOZE.
- IDLE:
  - trigger -> RING; ring_timer=0, snooze_cnt=0.
- RING, evaluated in this priority order:
  1. arm=0 -> IDLE.
  2. stop edge -> IDLE; snooze_cnt=0.
  3. snooze edge && snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; snooze_timer=SNOOZE_MIN*60-1. A snooze edge with snooze_cnt==MAX_SNOOZE is ignored.
  4. tick && ring_timer==RING_TIMEOUT_S-1 -> IDLE (timeout).
  5. Otherwise ring_timer increments on tick.
- SNOOZE, evaluated in this priority order:
  1. arm=0 -> IDLE.
  2. stop edge -> IDLE; snooze_cnt=0.
  3. tick && snooze_timer==0 -> RING; ring_timer=0.
  4. Otherwise snooze_timer decrements on tick.
  - Snooze edges are ignored in SNOOZE.
- Timer widths:
  - snooze_timer 16 bit, no wrap: loaded value <=899 for SNOOZE_MIN<=15.
  - ring_timer 8 bit; RING_TIMEOUT_S <=255.
- Buttons: edge = btn && !btn_d. A held button gives exactly one edge.
- On return to IDLE, snooze_cnt holds its last value until the next trigger or a stop edge.

Optional Feature:
- Macro: ALARM_MISSED_FLAG_EN.
- Defined:
  - missed sets to 1 on the RING timeout transition.
  - missed clears on a stop edge in any state or on a valid set_en.
  - If set and clear coincide, set wins.
- Undefined: missed tied to 0; no register inferred.

Test Plan:
- Set wrap and valid load:
  - Reset; set_en with set_hour=8'h07, set_minute=8'h30.
  - Then drive h=07,m=30,s=00 with arm=1.
  - Expect alarm_h=8'h07, alarm_m=8'h30; ring=1 one cycle after match; ring not retriggered while match is held.
- Invalid set:
  - set_en with set_hour=8'h24 or set_minute=8'h5A.
  - Expect set_err pulse of 1 cycle; alarm_h/alarm_m unchanged.
- Snooze cycle (SNOOZE_MIN=1):
  - Ringing; snooze edge.
  - Expect ring=0, snoozing=1, snooze_cnt=1.
  - After 60 ticks, ring=1 again.
  - Repeat until snooze_cnt=3; a fourth snooze edge is ignored and ring stays 1.
- Timeout (RING_TIMEOUT_S=60):
  - Ring with no buttons pressed.
  - On the 60th tick, state=IDLE and ring=0.
  - With ALARM_MISSED_FLAG_EN, missed=1; a later stop edge clears it.
- Priority and disarm:
  - Same cycle: stop edge, snooze edge and final timeout tick.
  - Expect IDLE with snooze_cnt=0.
  - Separately, arm dropped during SNOOZE -> IDLE, snoozing=0.
- Async reset mid-RING:
  - Expect all outputs at reset values immediately.
  - Alarm time reads 00:00; no ring after release until the next match rising edge.
